// File: rtl/frame_tx_pkg.sv
// frame_tx_pkg: shared definitions for the framed serial transmitter.
//   FLAG      - 7-bit frame delimiter, sent left bit first.
//   FLAG_LEN  - number of bits in FLAG.
//   STUFF_RUN - consecutive payload ones after which a 0 is stuffed.
//   BYTE_BITS - serial bits per payload byte (9 with parity, else 8).
//   state_e   - transmitter FSM states.
// Build option: define TX_PARITY_EN to add an even-parity bit after each byte.
package frame_tx_pkg;

  localparam logic [6:0]  FLAG      = 7'b0111110;
  localparam int unsigned FLAG_LEN  = 7;
  localparam int unsigned STUFF_RUN = 4;

`ifdef TX_PARITY_EN
  localparam int unsigned BYTE_BITS = 9;

  typedef enum logic [2:0] {
    StIdle,
    StOpenFlag,
    StShift,
    StStuff,
    StParity,
    StCloseFlag
  } state_e;
`else
  localparam int unsigned BYTE_BITS = 8;

  typedef enum logic [2:0] {
    StIdle,
    StOpenFlag,
    StShift,
    StStuff,
    StCloseFlag
  } state_e;
`endif

endpackage

// File: rtl/frame_tx_stuff_ctr.sv
// stuff_ctr: counts consecutive emitted ones (0..STUFF_RUN) and requests a stuff bit.
//   i_clk, i_rst_n - clock, asynchronous active-low reset
//   i_clear        - clear the run (frame start)
//   i_bit_en       - a counted bit is being emitted this cycle
//   i_bit          - value of that bit
//   o_stuff_req    - this cycle's bit completes a run of STUFF_RUN ones; a 0 is owed next
module stuff_ctr
  import frame_tx_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  input  logic i_bit_en,
  input  logic i_bit,
  output logic o_stuff_req
);

  logic [2:0] r_run;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_run <= '0;
    end else if (i_clear) begin
      r_run <= '0;
    end else if (i_bit_en) begin
      // The stuffed 0 itself arrives here as an emitted 0 and clears the run.
      r_run <= i_bit ? r_run + 3'd1 : 3'd0;
    end
  end

  assign o_stuff_req = i_bit_en & i_bit & (r_run == 3'(STUFF_RUN - 1));

endmodule

// File: rtl/frame_tx.sv
// frame_tx: flag-delimited, bit-stuffed serial frame transmitter.
//   i_clk, i_rst_n  - clock, asynchronous active-low reset
//   i_start, i_len  - frame request and payload byte count (sampled in idle only)
//   i_data_in       - payload byte, sent MSB first
//   i_data_valid    - i_data_in is valid
//   o_data_ready    - combinational: byte is taken this cycle if i_data_valid
//   o_ser_out       - serial line, idles high
//   o_busy          - frame in progress
//   o_done          - one-cycle pulse after the closing flag
//   o_err           - one-cycle pulse on payload underrun
// Build option: TX_PARITY_EN appends an even-parity bit to every byte.
module frame_tx
  import frame_tx_pkg::*;
#(
  parameter int unsigned LEN_W = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [LEN_W-1:0] i_len,
  input  logic [7:0]       i_data_in,
  input  logic             i_data_valid,
  output logic             o_data_ready,
  output logic             o_ser_out,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_err
);

  state_e           r_state, w_state_next;
  logic [2:0]       r_flag_cnt;
  logic [3:0]       r_bit_cnt;   // bits of the current byte already emitted
  logic [LEN_W-1:0] r_remain;
  logic [7:0]       r_shift;
  logic             r_done;
  logic             w_flag_last, w_flag_bit, w_avail, w_fetch_pt, w_load;
  logic             w_bit_en, w_bit, w_stuff_req;
`ifdef TX_PARITY_EN
  logic             r_par;
`endif

  assign w_flag_last = (r_flag_cnt == 3'(FLAG_LEN - 1));
  assign w_flag_bit  = FLAG[3'(FLAG_LEN - 1) - r_flag_cnt];
  assign w_avail     = (r_remain != '0) & i_data_valid;

  // Bits that take part in stuffing: payload, parity and the stuff bit itself.
`ifdef TX_PARITY_EN
  assign w_bit_en = (r_state == StShift) | (r_state == StStuff) | (r_state == StParity);
  assign w_bit    = (r_state == StShift) ? r_shift[7] : (r_state == StParity) ? r_par : 1'b0;
`else
  assign w_bit_en = (r_state == StShift) | (r_state == StStuff);
  assign w_bit    = (r_state == StShift) ? r_shift[7] : 1'b0;
`endif

  stuff_ctr u_stuff_ctr (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_clear    ((r_state == StIdle) & i_start),
    .i_bit_en   (w_bit_en),
    .i_bit      (w_bit),
    .o_stuff_req(w_stuff_req)
  );

  // A fetch point is the last cycle before the next byte's first bit would go out.
  always_comb begin
    w_state_next = r_state;
    w_fetch_pt   = 1'b0;
    o_ser_out    = 1'b1;
    unique case (r_state)
      StIdle: begin
        if (i_start) w_state_next = StOpenFlag;
      end
      StOpenFlag: begin
        o_ser_out = w_flag_bit;
        if (w_flag_last) begin
          w_fetch_pt   = 1'b1;
          w_state_next = w_avail ? StShift : StCloseFlag;
        end
      end
      StShift: begin
        o_ser_out = w_bit;
        if (w_stuff_req) begin
          w_state_next = StStuff;
        end else if (r_bit_cnt == 4'd7) begin
`ifdef TX_PARITY_EN
          w_state_next = StParity;
`else
          w_fetch_pt   = 1'b1;
          w_state_next = w_avail ? StShift : StCloseFlag;
`endif
        end
      end
`ifdef TX_PARITY_EN
      StParity: begin
        o_ser_out = w_bit;
        if (w_stuff_req) begin
          w_state_next = StStuff;
        end else begin
          w_fetch_pt   = 1'b1;
          w_state_next = w_avail ? StShift : StCloseFlag;
        end
      end
`endif
      StStuff: begin
        o_ser_out = 1'b0;
        if (r_bit_cnt < 4'd8) begin
          w_state_next = StShift;
`ifdef TX_PARITY_EN
        end else if (r_bit_cnt == 4'd8) begin
          w_state_next = StParity;
`endif
        end else begin
          w_fetch_pt   = 1'b1;
          w_state_next = w_avail ? StShift : StCloseFlag;
        end
      end
      StCloseFlag: begin
        o_ser_out = w_flag_bit;
        if (w_flag_last) w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  assign o_data_ready = w_fetch_pt & (r_remain != '0);
  assign o_err        = o_data_ready & ~i_data_valid;
  assign w_load       = o_data_ready & i_data_valid;
  assign o_busy       = (r_state != StIdle);
  assign o_done       = r_done;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= StIdle;
      r_flag_cnt <= '0;
      r_bit_cnt  <= '0;
      r_remain   <= '0;
      r_shift    <= '0;
      r_done     <= 1'b0;
`ifdef TX_PARITY_EN
      r_par      <= 1'b0;
`endif
    end else begin
      r_state <= w_state_next;
      r_done  <= (r_state == StCloseFlag) & w_flag_last;
      if (((r_state == StOpenFlag) || (r_state == StCloseFlag)) && !w_flag_last) begin
        r_flag_cnt <= r_flag_cnt + 3'd1;
      end else begin
        r_flag_cnt <= '0;
      end
      if ((r_state == StIdle) && i_start) r_remain <= i_len;
      if (w_load) begin
        r_shift   <= i_data_in;
        r_bit_cnt <= '0;
        r_remain  <= r_remain - LEN_W'(1);
`ifdef TX_PARITY_EN
        r_par     <= ^i_data_in;
`endif
      end else if (r_state == StShift) begin
        r_shift   <= {r_shift[6:0], 1'b0};
        r_bit_cnt <= r_bit_cnt + 4'd1;
`ifdef TX_PARITY_EN
      end else if (r_state == StParity) begin
        r_bit_cnt <= r_bit_cnt + 4'd1;
`endif
      end
    end
  end

endmodule

// File: doc/frame_tx.md
FRAME_TX -- requirements
Module: frame_tx

Interface
REQ-001 Parameter LEN_W, default 4, width of the frame byte-count input.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  frame request; sampled only in IDLE.
REQ-005 len  input  LEN_W  payload byte count, captured with start; 0 = empty frame.
REQ-006 data_in  input  8  payload byte, sent MSB first.
REQ-007 data_valid  input  1  data_in holds a valid byte.
REQ-008 data_ready  output  1  combinational; high in each byte-fetch cycle (REQ-015).
REQ-009 serOut  output  1  serial line; idles at 1.
REQ-010 busy  output  1  high from the cycle after start acceptance until done.
REQ-011 done  output  1  one-cycle pulse after the last closing-flag bit.
REQ-012 err  output  1  one-cycle pulse on payload underrun.

Function
REQ-013 FSM states: IDLE, OPEN_FLAG, SHIFT, STUFF, (PARITY), CLOSE_FLAG; serOut is 1 in IDLE.
REQ-014 start=1 in IDLE captures len; the next cycle emits flag bit 0 of 0111110 (left bit first), 7 cycles.
REQ-015 Byte fetch happens in the last open-flag cycle, and in the cycle that emits the last bit of a byte (or its parity bit, or a stuff bit immediately following it); the fetch happens only while bytes remain; byte captured when data_valid=1 in that cycle, with no serial gap.
REQ-016 Fetch with data_valid=0 is an underrun: err pulses, the remaining payload is dropped, and the closing flag starts next cycle.
REQ-017 Stuffing: a run counter (0..4) counts consecutive payload 1s and persists across byte boundaries; after the fourth 1 the next cycle emits a stuffed 0 (STUFF), the shift pauses and the counter clears; any emitted 0 clears it.
REQ-018 A stuff bit owed after the final payload bit is emitted before the closing flag.
REQ-019 The run counter clears at frame start; flag bits never count.
REQ-020 After the last payload byte (or immediately when len=0), CLOSE_FLAG emits 0111110 over 7 cycles; the next cycle returns to IDLE with serOut=1, busy=0, and done=1.
REQ-021 start while busy is ignored.
REQ-022 Consequence: the payload never contains more than four consecutive 1s, so 0111110 never appears between flags.

Reset
REQ-023 rst_n=0 forces IDLE immediately, regardless of clk: serOut=1, busy=0, done=0, err=0, data_ready=0, counters 0.
REQ-024 Reset mid-frame aborts with no closing flag; after release the block waits for a new start.

Configuration
REQ-025 Macro TX_PARITY_EN defined: after each byte's 8 bits, one even-parity bit over those 8 bits is emitted; the parity bit is subject to stuffing and counting.
REQ-026 TX_PARITY_EN undefined: no PARITY state and bytes are 8 bits; all other behaviour is identical.

Structure
REQ-027 Package frame_tx_pkg holds the state enum, FLAG = 7'b0111110, FLAG_LEN = 7 and STUFF_RUN = 4.
REQ-028 One sub-module, stuff_ctr: the ones-run counter with a stuff-request output; everything else lives in frame_tx.

Verification
REQ-029 len=0, start pulse -> serOut 1, then 01111100111110, then 1; done pulses once; data_ready never high.
REQ-030 len=1, 0xFF, parity off -> flag, 1111 0 1111 0, flag; exactly 2 stuff bits.
REQ-031 len=2, 0xF0 then 0x0F -> flag, 11110 0 000 0000 1111 0, flag; data_ready high exactly twice; no gap cycles.
REQ-032 len=3, data_valid dropped at the second fetch -> err pulses once, only byte 1 is sent, then the closing flag and done.
REQ-033 rst_n low during byte 1 -> serOut=1 and busy=0 in the same cycle; a new start afterwards sends a correct frame.
REQ-034 Random payloads, 200 frames, with a 0111110 pattern checker on serOut -> exactly 2 detections per frame (TX_PARITY_EN both defined and undefined).
